// File: rtl/calu_multiword_addsub_ctrl.sv
// Multi-precision add/sub sequencer around a single-word adder: feeds one word per cycle,
// LS word first, chains the carry, and returns the assembled result with Z/N/C/V flags.
module calu_multiword_addsub_ctrl #(
   parameter int unsigned WORD_W    = 16,
   parameter int unsigned MAX_WORDS = 4,
   parameter int unsigned LEN_W     = $clog2(MAX_WORDS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_sub,
   input  logic [LEN_W-1:0]            req_len,
   input  logic [WORD_W*MAX_WORDS-1:0] req_a,
   input  logic [WORD_W*MAX_WORDS-1:0] req_b,
   output logic [WORD_W-1:0]           add_A,
   output logic [WORD_W-1:0]           add_B,
   output logic                        add_Sub,
   output logic                        add_Cin,
   input  logic [WORD_W-1:0]           add_Result,
   input  logic                        add_Cout,
   input  logic                        add_Overflow,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [WORD_W*MAX_WORDS-1:0] rsp_result,
   output logic                        rsp_c,
   output logic                        rsp_v,
   output logic                        rsp_z,
   output logic                        rsp_n
);

   localparam int unsigned TotW = WORD_W * MAX_WORDS;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q;
   logic [TotW-1:0]     a_q, b_q, result_q;
   logic                sub_q;
   logic [LEN_W-1:0]    len_q, idx_q;
   logic [WORD_W-1:0]   add_a_q, add_b_q;
   logic                add_cin_q;
   logic                rsp_c_q, rsp_v_q, rsp_z_q, rsp_n_q;

   logic [LEN_W-1:0]    idx_nxt;
   logic [WORD_W-1:0]   a_nxt, b_nxt;
   logic [TotW-1:0]     result_upd;
   logic                last;

   assign idx_nxt = idx_q + LEN_W'(1);
   assign a_nxt   = a_q[idx_nxt*WORD_W +: WORD_W];
   assign b_nxt   = sub_q ? ~b_q[idx_nxt*WORD_W +: WORD_W] : b_q[idx_nxt*WORD_W +: WORD_W];
   assign last    = (idx_q == len_q);

   always_comb begin
      result_upd = result_q;
      result_upd[idx_q*WORD_W +: WORD_W] = add_Result;
   end

   // Adder inputs are registered so the adder sees glitch-free operands and carry-in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         sub_q     <= 1'b0;
         len_q     <= '0;
         idx_q     <= '0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         add_cin_q <= 1'b0;
         rsp_c_q   <= 1'b0;
         rsp_v_q   <= 1'b0;
         rsp_z_q   <= 1'b0;
         rsp_n_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  a_q       <= req_a;
                  b_q       <= req_b;
                  sub_q     <= req_sub;
                  len_q     <= req_len;
                  idx_q     <= '0;
                  result_q  <= '0;
                  add_a_q   <= req_a[WORD_W-1:0];
                  add_b_q   <= req_sub ? ~req_b[WORD_W-1:0] : req_b[WORD_W-1:0];
                  add_cin_q <= req_sub;
                  rsp_c_q   <= 1'b0;
                  rsp_v_q   <= 1'b0;
                  rsp_z_q   <= 1'b0;
                  rsp_n_q   <= 1'b0;
                  state_q   <= StRun;
               end
            end
            StRun: begin
               result_q <= result_upd;
               if (last) begin
                  add_a_q   <= '0;
                  add_b_q   <= '0;
                  add_cin_q <= 1'b0;
                  rsp_c_q   <= add_Cout;
                  rsp_v_q   <= add_Overflow;
                  rsp_z_q   <= (result_upd == '0);
                  rsp_n_q   <= add_Result[WORD_W-1];
                  state_q   <= StDone;
               end else begin
                  idx_q     <= idx_nxt;
                  add_a_q   <= a_nxt;
                  add_b_q   <= b_nxt;
                  add_cin_q <= add_Cout;
               end
            end
            StDone: begin
               if (rsp_ready) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready  = rst_n && (state_q == StIdle);
   assign rsp_valid  = (state_q == StDone);
   assign add_A      = add_a_q;
   assign add_B      = add_b_q;
   assign add_Cin    = add_cin_q;
   assign add_Sub    = 1'b0;
   assign rsp_result = result_q;
   assign rsp_c      = rsp_c_q;
   assign rsp_v      = rsp_v_q;
   assign rsp_z      = rsp_z_q;
   assign rsp_n      = rsp_n_q;

endmodule

// File: tb/tb_calu_multiword_addsub_ctrl.sv
// Bench for calu_multiword_addsub_ctrl: models the 16-bit adder and checks each request
// against a whole-operand arithmetic reference.
module tb_calu_multiword_addsub_ctrl;

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned MAX_WORDS = 4;
   localparam int unsigned LEN_W     = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_sub = 1'b0;
   logic [1:0]  req_len = '0;
   logic [63:0] req_a = '0, req_b = '0;
   logic [15:0] add_A, add_B, add_Result;
   logic        add_Sub, add_Cin, add_Cout, add_Overflow;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [63:0] rsp_result;
   logic        rsp_c, rsp_v, rsp_z, rsp_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   calu_multiword_addsub_ctrl #(
      .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub), .req_len(req_len),
      .req_a(req_a), .req_b(req_b),
      .add_A(add_A), .add_B(add_B), .add_Sub(add_Sub), .add_Cin(add_Cin),
      .add_Result(add_Result), .add_Cout(add_Cout), .add_Overflow(add_Overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_z(rsp_z), .rsp_n(rsp_n)
   );

   // Combinational 16-bit adder the controller drives.
   logic [16:0] add_sum;
   assign add_sum      = {1'b0, add_A} + {1'b0, add_B} + {16'd0, add_Cin};
   assign add_Result   = add_sum[15:0];
   assign add_Cout     = add_sum[16];
   assign add_Overflow = (add_A[15] == add_B[15]) && (add_sum[15] != add_A[15]);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic scramble_req();
      req_sub = 1'($urandom);
      req_len = 2'($urandom);
      req_a   = {$urandom, $urandom};
      req_b   = {$urandom, $urandom};
   endtask

   task automatic run_req(input logic sub, input int len, input logic [63:0] a,
                          input logic [63:0] b, input int bp, input bit early_ready);
      int          nb, cycles;
      logic [64:0] mask, mk, am, bx, sum, part;
      logic [63:0] exp_res, snap;
      logic        exp_c, exp_v, exp_n, exp_cin;
      nb   = 16 * (len + 1);
      mask = (65'd1 << nb) - 65'd1;
      am   = {1'b0, a} & mask;
      bx   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
      sum  = am + bx + {64'd0, sub};
      exp_res = sum[63:0] & mask[63:0];
      exp_c   = sum[nb];
      exp_n   = sum[nb-1];
      exp_v   = (am[nb-1] == bx[nb-1]) && (sum[nb-1] != am[nb-1]);

      @(negedge clk);
      check_eq("req_ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_sub = sub; req_len = 2'(len); req_a = a; req_b = b;
      rsp_ready = early_ready;
      @(posedge clk); #1;
      req_valid = 1'b0;
      scramble_req();
      cycles = 0;
      while (!rsp_valid && cycles < 20) begin
         check_eq("req_ready_run", {63'd0, req_ready}, 64'd0);
         if (cycles <= len) begin
            mk   = (65'd1 << (16 * cycles)) - 65'd1;
            part = (am & mk) + (bx & mk) + {64'd0, sub};
            exp_cin = part[16 * cycles];
            check_eq("add_A", {48'd0, add_A}, {48'd0, a[cycles*16 +: 16]});
            check_eq("add_B", {48'd0, add_B},
                     {48'd0, sub ? ~b[cycles*16 +: 16] : b[cycles*16 +: 16]});
            check_eq("add_Cin", {63'd0, add_Cin}, {63'd0, exp_cin});
         end
         @(posedge clk); #1;
         cycles++;
      end
      check_eq("latency", 64'(cycles), 64'(len + 1));
      check_eq("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check_eq("rsp_result", rsp_result, exp_res);
      check_eq("rsp_c", {63'd0, rsp_c}, {63'd0, exp_c});
      check_eq("rsp_v", {63'd0, rsp_v}, {63'd0, exp_v});
      check_eq("rsp_z", {63'd0, rsp_z}, {63'd0, exp_res == 64'd0});
      check_eq("rsp_n", {63'd0, rsp_n}, {63'd0, exp_n});
      check_eq("add_idle_done", {47'd0, add_A, add_B, add_Cin}, 64'd0);
      snap = rsp_result;
      if (!early_ready) begin
         for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            check_eq("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check_eq("bp_req_ready", {63'd0, req_ready}, 64'd0);
            check_eq("bp_result", rsp_result, snap);
            check_eq("bp_flags", {60'd0, rsp_c, rsp_v, rsp_z, rsp_n},
                     {60'd0, exp_c, exp_v, exp_res == 64'd0, exp_n});
         end
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      check_eq("post_hs_valid", {63'd0, rsp_valid}, 64'd0);
      check_eq("post_hs_ready", {63'd0, req_ready}, 64'd1);
      check_eq("post_hs_add", {47'd0, add_A, add_B, add_Cin}, 64'd0);
   endtask

   initial begin
      #1;
      check_eq("rst_ready", {63'd0, req_ready}, 64'd0);
      check_eq("rst_valid", {63'd0, rsp_valid}, 64'd0);
      check_eq("rst_add", {47'd0, add_A, add_B, add_Cin}, 64'd0);
      check_eq("rst_rsp", rsp_result, 64'd0);
      check_eq("add_Sub", {63'd0, add_Sub}, 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rel_ready", {63'd0, req_ready}, 64'd1);

      run_req(1'b0, 0, 64'h4000, 64'h4000, 0, 1'b0);
      run_req(1'b0, 1, 64'h0000_FFFF, 64'h1, 0, 1'b0);
      run_req(1'b1, 1, 64'h0001_0000, 64'h1, 0, 1'b1);
      run_req(1'b1, 3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);
      run_req(1'b0, 2, 64'h7FFF_FFFF_FFFF, 64'h1, 3, 1'b0);
      run_req(1'b1, 3, 64'h0, 64'h1, 1, 1'b0);

      // Reset while the third word is on the adder.
      @(negedge clk);
      req_valid = 1'b1; req_sub = 1'b0; req_len = 2'd3;
      req_a = 64'hFFFF_FFFF_FFFF_FFFF; req_b = 64'h1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("mid_run_cin", {63'd0, add_Cin}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mr_valid", {63'd0, rsp_valid}, 64'd0);
      check_eq("mr_ready", {63'd0, req_ready}, 64'd0);
      check_eq("mr_add", {47'd0, add_A, add_B, add_Cin}, 64'd0);
      check_eq("mr_rsp", {rsp_result[59:0], rsp_c, rsp_v, rsp_z, rsp_n}, 64'd0);
      check_eq("mr_rsp_hi", {60'd0, rsp_result[63:60]}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("mr_rel_ready", {63'd0, req_ready}, 64'd1);
      run_req(1'b1, 0, 64'h5, 64'h7, 0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         run_req(1'($urandom), int'($urandom_range(0, 3)), {$urandom, $urandom},
                 {$urandom, $urandom}, int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
